// File: rtl/clk_div_prog.sv
// Programmable divided-clock generator with registered mclk, rise/fall strobes and
// glitch-free divisor reload at period boundaries. Define CLKDIV_SYNC_EN to add a `sync` phase-align input.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             busy,
  output logic [WIDTH-1:0] cur_div,
  output logic             mclk,
  output logic             rise_tick,
  output logic             fall_tick
);

  localparam logic [WIDTH-1:0] RESET_DIV = (DEFAULT_DIV < 2) ? WIDTH'(2) : WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pending_clamped;
  logic             wrap;
  logic             apply;
  logic             mclk_next;
  logic             sync_hit;

`ifdef CLKDIV_SYNC_EN
  assign sync_hit = sync;
`else
  assign sync_hit = 1'b0;
`endif

  // The low phase is floor(N/2) cycles, so odd divisors stretch the high phase.
  always_comb begin
    pending_clamped = (pending < WIDTH'(2)) ? WIDTH'(2) : pending;
    wrap            = en && (cnt == cur_div - 1'b1);
    apply           = busy && (sync_hit || wrap);
    cnt_next        = wrap ? '0 : cnt + 1'b1;
    mclk_next       = (cnt_next >= (cur_div >> 1));
  end

  // NOTE: all state uses <= so every term above reads the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      mclk      <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      busy      <= 1'b0;
      pending   <= '0;
      cur_div   <= RESET_DIV;
    end else begin
      if (sync_hit) begin
        cnt       <= '0;
        mclk      <= 1'b0;
        rise_tick <= 1'b0;
        fall_tick <= mclk;
      end else if (en) begin
        cnt       <= cnt_next;
        mclk      <= mclk_next;
        rise_tick <= !mclk && mclk_next;
        fall_tick <= mclk && !mclk_next;
      end else begin
        rise_tick <= 1'b0;
        fall_tick <= 1'b0;
      end

      if (apply) begin
        cur_div <= pending_clamped;
      end

      // A load landing on the apply edge is kept for the following boundary.
      if (div_load) begin
        pending <= div_in;
        busy    <= 1'b1;
      end else if (apply) begin
        busy    <= 1'b0;
      end
    end
  end

endmodule
